// File: rtl/cart_rom_reader.sv
// DMG cartridge ROM read sequencer: one-cycle strobe in, timed SETUP/ACCESS/HOLD bus cycle out.
// Optional CART_PHI_EN adds a free-running 1 MHz cart_phi divider output.
module cart_rom_reader #(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic [15:0] rom_addr,
  input  logic        rom_rd,
  output logic [7:0]  rom_data,
  output logic        rom_bsy,
  output logic [15:0] cart_a,
  input  logic [7:0]  cart_d,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n
`ifdef CART_PHI_EN
  ,
  output logic        cart_phi
`endif
);

  localparam int MAX_SA = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int MAXC   = (MAX_SA > HOLD_CYC) ? MAX_SA : HOLD_CYC;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] ACCESS_LD = CW'(ACCESS_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Combinational so the requester sees busy in its own strobe cycle.
  assign rom_bsy   = (rom_rd && state == IDLE) || state != IDLE;
  assign cart_wr_n = 1'b1;

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rom_data  <= 8'h00;
      cart_a    <= 16'h0000;
      cart_rd_n <= 1'b1;
      cart_cs_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rom_rd) begin
            cart_a    <= rom_addr;
            cart_cs_n <= !(rom_addr >= 16'hA000);
            cnt       <= SETUP_LD;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt       <= ACCESS_LD;
            cart_rd_n <= 1'b0;
            state     <= ACCESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            rom_data  <= cart_d;
            cart_rd_n <= 1'b1;
            cnt       <= HOLD_LD;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cart_cs_n <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CART_PHI_EN
  logic [2:0] phi_cnt;

  always_ff @(posedge clk_8m) begin
    if (rst) phi_cnt <= 3'd0;
    else     phi_cnt <= phi_cnt + 3'd1;
  end

  assign cart_phi = phi_cnt[2];
`endif

endmodule

// File: tb/tb_cart_rom_reader.sv
// Bench for cart_rom_reader: default and (2,1,2) instances driven in parallel, checked each
// cycle against a per-request timeline model.
module tb_cart_rom_reader;

  logic             clk = 1'b0;
  logic             rst, rom_rd;
  logic [15:0]      rom_addr;
  logic [1:0]       bsy, rdn, wrn, csn;
  logic [1:0][15:0] ca;
  logic [1:0][7:0]  rdat, cd;
`ifdef CART_PHI_EN
  logic [1:0]       phi;
`endif

  logic [7:0] mem [0:65535];

  always #62 clk = ~clk;

  // Cart model: drives the ROM byte only while the read strobe is low.
  assign cd[0] = rdn[0] ? 8'hFF : mem[ca[0]];
  assign cd[1] = rdn[1] ? 8'hFF : mem[ca[1]];

  cart_rom_reader u_dflt (
    .clk_8m(clk), .rst(rst), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_data(rdat[0]), .rom_bsy(bsy[0]), .cart_a(ca[0]), .cart_d(cd[0]),
    .cart_rd_n(rdn[0]), .cart_wr_n(wrn[0]), .cart_cs_n(csn[0])
`ifdef CART_PHI_EN
    , .cart_phi(phi[0])
`endif
  );

  cart_rom_reader #(.SETUP_CYC(2), .ACCESS_CYC(1), .HOLD_CYC(2)) u_alt (
    .clk_8m(clk), .rst(rst), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_data(rdat[1]), .rom_bsy(bsy[1]), .cart_a(ca[1]), .cart_d(cd[1]),
    .cart_rd_n(rdn[1]), .cart_wr_n(wrn[1]), .cart_cs_n(csn[1])
`ifdef CART_PHI_EN
    , .cart_phi(phi[1])
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Model: each request is a timeline t=1..L-1 after the accept cycle.
  int          sc[2] = '{1, 2};
  int          ac[2] = '{3, 1};
  int          hc[2] = '{1, 2};
  bit          act[2];
  int          t[2];
  logic [15:0] ea[2];
  logic [7:0]  ed[2];
  int          phc;

  task automatic req(input logic [15:0] a);
    rom_rd   = 1'b1;
    rom_addr = a;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0104] = 8'hCE;
    rst = 1'b1; rom_rd = 1'b0; rom_addr = 16'h0000;
    for (int i = 0; i < 2; i++) begin act[i] = 0; t[i] = 0; ea[i] = '0; ed[i] = '0; end
    phc = 0;

    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      cyc = n;
      rst = 1'b0; rom_rd = 1'b0; rom_addr = 16'($urandom);
      case (n)
        0, 1: rst = 1'b1;
        2:    req(16'h0104);
        5:    req(16'h0200);          // while busy: must be lost
        10:   req(16'hA000);
        16:   req(16'h9FFF);
        22:   req(16'h0104);
        25:   rst = 1'b1;             // reset mid-access
        27:   req(16'h0105);
        33:   req(16'd260);
        39:   req(16'd261);           // back-to-back, first IDLE cycle
        45:   begin rst = 1'b1; req(16'h0300); end
        default: ;
      endcase
      if (n >= 50) begin
        if ($urandom_range(0, 59) == 0) rst = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0: req(16'hA000 - 16'($urandom_range(0, 2)));
            1: req(16'hA000 + 16'($urandom_range(0, 2)));
            default: req(16'($urandom));
          endcase
        end
      end

      @(negedge clk);
      if (n >= 1) begin
        for (int i = 0; i < 2; i++) begin
          logic e_bsy, e_rdn, e_csn;
          if (!act[i]) begin
            e_bsy = rom_rd; e_rdn = 1'b1; e_csn = 1'b1;
          end else begin
            e_bsy = 1'b1;
            e_rdn = !(t[i] >= 1 + sc[i] && t[i] <= sc[i] + ac[i]);
            e_csn = !(ea[i] >= 16'hA000);
          end
          chk($sformatf("bsy%0d", i), 32'(bsy[i]), 32'(e_bsy));
          chk($sformatf("rd_n%0d", i), 32'(rdn[i]), 32'(e_rdn));
          chk($sformatf("cs_n%0d", i), 32'(csn[i]), 32'(e_csn));
          chk($sformatf("wr_n%0d", i), 32'(wrn[i]), 32'd1);
          chk($sformatf("addr%0d", i), 32'(ca[i]), 32'(ea[i]));
          chk($sformatf("data%0d", i), 32'(rdat[i]), 32'(ed[i]));
`ifdef CART_PHI_EN
          chk($sformatf("phi%0d", i), 32'(phi[i]), 32'((phc % 8) >= 4));
`endif
        end
      end

      // Advance the model across the coming edge.
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          act[i] = 0; ea[i] = '0; ed[i] = '0;
        end else if (!act[i]) begin
          if (rom_rd) begin act[i] = 1; t[i] = 1; ea[i] = rom_addr; end
        end else begin
          if (t[i] == sc[i] + ac[i]) ed[i] = mem[ea[i]];
          if (t[i] == sc[i] + ac[i] + hc[i]) act[i] = 0;
          else t[i]++;
        end
      end
      phc = rst ? 0 : phc + 1;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
